// File: rtl/e203_exu_wbck_arb.sv
// e203_exu_wbck_arb
// Write-back arbiter in front of the GPR file's single write port.
// Single-cycle ALU results go straight through. Long-pipe (LSU/MulDiv) results
// are queued in a small FIFO. The FIFO drains when the ALU is idle, or
// unconditionally when the FIFO is full.
//
// Optional feature macro: E203_WBCK_ARB_BYPASS_EN
//   When defined, a long-pipe result that arrives while the FIFO is empty and
//   the ALU is idle is written in the same cycle instead of being queued.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   alu_wbck_i_*                ALU result handshake (valid/ready, wdat, rdidx)
//   longp_wbck_i_*              long-pipe result handshake (valid/ready, wdat, rdidx)
//   rf_wbck_o_ena/wdat/rdidx    register-file write port
//   longp_fifo_cnt              current long-pipe FIFO occupancy
module e203_exu_wbck_arb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RFIDX_W  = 5,
    parameter int unsigned LP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       alu_wbck_i_valid,
    output logic                       alu_wbck_i_ready,
    input  logic [XLEN-1:0]            alu_wbck_i_wdat,
    input  logic [RFIDX_W-1:0]         alu_wbck_i_rdidx,

    input  logic                       longp_wbck_i_valid,
    output logic                       longp_wbck_i_ready,
    input  logic [XLEN-1:0]            longp_wbck_i_wdat,
    input  logic [RFIDX_W-1:0]         longp_wbck_i_rdidx,

    output logic                       rf_wbck_o_ena,
    output logic [XLEN-1:0]            rf_wbck_o_wdat,
    output logic [RFIDX_W-1:0]         rf_wbck_o_rdidx,

    output logic [$clog2(LP_DEPTH):0]  longp_fifo_cnt
);

    localparam int unsigned PTR_W = $clog2(LP_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // FIFO storage and bookkeeping
    logic [XLEN-1:0]    fifo_wdat  [LP_DEPTH];
    logic [RFIDX_W-1:0] fifo_rdidx [LP_DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [CNT_W-1:0]   cnt;

    logic fifo_full;
    logic fifo_empty;
    logic sel_fifo;
    logic sel_alu;
    logic bypass_take;
    logic push;
    logic pop;
    logic sel_valid;

    assign fifo_full  = (cnt == CNT_W'(LP_DEPTH));
    assign fifo_empty = (cnt == '0);

    // FIFO head wins when ALU is idle, or always when the FIFO is full
    assign sel_fifo = ~rst & ~fifo_empty & (~alu_wbck_i_valid | fifo_full);
    assign sel_alu  = ~rst & alu_wbck_i_valid & ~sel_fifo;

`ifdef E203_WBCK_ARB_BYPASS_EN
    // Empty FIFO and idle ALU: write the long-pipe result directly
    assign bypass_take = ~rst & fifo_empty & ~alu_wbck_i_valid & longp_wbck_i_valid;
`else
    assign bypass_take = 1'b0;
`endif

    // Ready does not account for a same-cycle pop, so a full FIFO never accepts
    assign alu_wbck_i_ready   = ~rst & ~sel_fifo;
    assign longp_wbck_i_ready = ~rst & ~fifo_full;

    assign push = longp_wbck_i_valid & longp_wbck_i_ready & ~bypass_take;
    assign pop  = sel_fifo;

    // Write-port source mux; sources are mutually exclusive by construction
    always_comb begin
        sel_valid       = 1'b0;
        rf_wbck_o_wdat  = '0;
        rf_wbck_o_rdidx = '0;
        if (sel_fifo) begin
            sel_valid       = 1'b1;
            rf_wbck_o_wdat  = fifo_wdat[rptr];
            rf_wbck_o_rdidx = fifo_rdidx[rptr];
        end else if (sel_alu) begin
            sel_valid       = 1'b1;
            rf_wbck_o_wdat  = alu_wbck_i_wdat;
            rf_wbck_o_rdidx = alu_wbck_i_rdidx;
        end else if (bypass_take) begin
            sel_valid       = 1'b1;
            rf_wbck_o_wdat  = longp_wbck_i_wdat;
            rf_wbck_o_rdidx = longp_wbck_i_rdidx;
        end
    end

    // x0 writes complete their handshake but never reach the register file
    assign rf_wbck_o_ena = sel_valid & (rf_wbck_o_rdidx != '0);

    // Entry storage; contents are qualified by cnt, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wdat[wptr]  <= longp_wbck_i_wdat;
            fifo_rdidx[wptr] <= longp_wbck_i_rdidx;
        end
    end

    // Pointers wrap naturally since LP_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign longp_fifo_cnt = cnt;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Directed testbench for e203_exu_wbck_arb (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 time
// unit later, well before the next rising edge.
module tb_e203_exu_wbck_arb;

    logic        clk;
    logic        rst;
    logic        alu_wbck_i_valid;
    logic        alu_wbck_i_ready;
    logic [31:0] alu_wbck_i_wdat;
    logic [4:0]  alu_wbck_i_rdidx;
    logic        longp_wbck_i_valid;
    logic        longp_wbck_i_ready;
    logic [31:0] longp_wbck_i_wdat;
    logic [4:0]  longp_wbck_i_rdidx;
    logic        rf_wbck_o_ena;
    logic [31:0] rf_wbck_o_wdat;
    logic [4:0]  rf_wbck_o_rdidx;
    logic [2:0]  longp_fifo_cnt;

    int n_cmp = 0;
    int n_err = 0;

    e203_exu_wbck_arb #(.XLEN(32), .RFIDX_W(5), .LP_DEPTH(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .alu_wbck_i_valid   (alu_wbck_i_valid),
        .alu_wbck_i_ready   (alu_wbck_i_ready),
        .alu_wbck_i_wdat    (alu_wbck_i_wdat),
        .alu_wbck_i_rdidx   (alu_wbck_i_rdidx),
        .longp_wbck_i_valid (longp_wbck_i_valid),
        .longp_wbck_i_ready (longp_wbck_i_ready),
        .longp_wbck_i_wdat  (longp_wbck_i_wdat),
        .longp_wbck_i_rdidx (longp_wbck_i_rdidx),
        .rf_wbck_o_ena      (rf_wbck_o_ena),
        .rf_wbck_o_wdat     (rf_wbck_o_wdat),
        .rf_wbck_o_rdidx    (rf_wbck_o_rdidx),
        .longp_fifo_cnt     (longp_fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                         input logic lv, input logic [4:0] li, input logic [31:0] ld);
        alu_wbck_i_valid   = av;
        alu_wbck_i_rdidx   = ai;
        alu_wbck_i_wdat    = ad;
        longp_wbck_i_valid = lv;
        longp_wbck_i_rdidx = li;
        longp_wbck_i_wdat  = ld;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd8, 32'h2);
        tick();
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd8, 32'h2);
        n_cmp++; if (alu_wbck_i_ready !== 1'b0) begin n_err++; $display("FAIL rst_alu_ready got=%b exp=0", alu_wbck_i_ready); end
        n_cmp++; if (longp_wbck_i_ready !== 1'b0) begin n_err++; $display("FAIL rst_longp_ready got=%b exp=0", longp_wbck_i_ready); end
        n_cmp++; if (rf_wbck_o_ena !== 1'b0) begin n_err++; $display("FAIL rst_ena got=%b exp=0", rf_wbck_o_ena); end
        tick();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL post_rst_cnt got=%0d exp=0", longp_fifo_cnt); end
        n_cmp++; if (alu_wbck_i_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_alu_ready got=%b exp=1", alu_wbck_i_ready); end
        n_cmp++; if (longp_wbck_i_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_longp_ready got=%b exp=1", longp_wbck_i_ready); end
        n_cmp++; if (rf_wbck_o_ena !== 1'b0) begin n_err++; $display("FAIL idle_ena got=%b exp=0", rf_wbck_o_ena); end
        tick();
    endtask

    task automatic test_alu_only();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (alu_wbck_i_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready got=%b exp=1", alu_wbck_i_ready); end
        n_cmp++; if (rf_wbck_o_ena !== 1'b1) begin n_err++; $display("FAIL alu_ena got=%b exp=1", rf_wbck_o_ena); end
        n_cmp++; if (rf_wbck_o_rdidx !== 5'd5) begin n_err++; $display("FAIL alu_rdidx got=%0d exp=5", rf_wbck_o_rdidx); end
        n_cmp++; if (rf_wbck_o_wdat !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_wdat got=%h exp=deadbeef", rf_wbck_o_wdat); end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL alu_cnt got=%0d exp=0", longp_fifo_cnt); end
        tick();
    endtask

    task automatic test_longp_idle();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h12);
        n_cmp++; if (longp_wbck_i_ready !== 1'b1) begin n_err++; $display("FAIL lp_ready got=%b exp=1", longp_wbck_i_ready); end
`ifdef E203_WBCK_ARB_BYPASS_EN
        n_cmp++; if (rf_wbck_o_ena !== 1'b1) begin n_err++; $display("FAIL lp_byp_ena got=%b exp=1", rf_wbck_o_ena); end
        n_cmp++; if (rf_wbck_o_rdidx !== 5'd3) begin n_err++; $display("FAIL lp_byp_rdidx got=%0d exp=3", rf_wbck_o_rdidx); end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL lp_byp_cnt got=%0d exp=0", longp_fifo_cnt); end
        n_cmp++; if (rf_wbck_o_ena !== 1'b0) begin n_err++; $display("FAIL lp_byp_ena2 got=%b exp=0", rf_wbck_o_ena); end
`else
        n_cmp++; if (rf_wbck_o_ena !== 1'b0) begin n_err++; $display("FAIL lp_push_ena got=%b exp=0", rf_wbck_o_ena); end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd1) begin n_err++; $display("FAIL lp_cnt1 got=%0d exp=1", longp_fifo_cnt); end
        n_cmp++; if (rf_wbck_o_ena !== 1'b1) begin n_err++; $display("FAIL lp_pop_ena got=%b exp=1", rf_wbck_o_ena); end
        n_cmp++; if (rf_wbck_o_rdidx !== 5'd3) begin n_err++; $display("FAIL lp_pop_rdidx got=%0d exp=3", rf_wbck_o_rdidx); end
        n_cmp++; if (rf_wbck_o_wdat !== 32'h12) begin n_err++; $display("FAIL lp_pop_wdat got=%h exp=12", rf_wbck_o_wdat); end
`endif
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL lp_cnt0 got=%0d exp=0", longp_fifo_cnt); end
        tick();
    endtask

    task automatic test_full();
        // ALU busy throughout: four pushes, each cycle the ALU is written
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd7, 32'hA0, 1'b1, 5'(10 + i), 32'(100 + i));
            n_cmp++; if (rf_wbck_o_rdidx !== 5'd7 || rf_wbck_o_ena !== 1'b1) begin n_err++; $display("FAIL full_fill%0d got=%b/%0d exp=1/7", i, rf_wbck_o_ena, rf_wbck_o_rdidx); end
            tick();
        end
        // Full: longp offers a fifth entry that must be refused
        drive(1'b1, 5'd7, 32'hA0, 1'b1, 5'd30, 32'h999);
        n_cmp++; if (longp_fifo_cnt !== 3'd4) begin n_err++; $display("FAIL full_cnt got=%0d exp=4", longp_fifo_cnt); end
        n_cmp++; if (longp_wbck_i_ready !== 1'b0) begin n_err++; $display("FAIL full_lp_ready got=%b exp=0", longp_wbck_i_ready); end
        n_cmp++; if (alu_wbck_i_ready !== 1'b0) begin n_err++; $display("FAIL full_alu_ready got=%b exp=0", alu_wbck_i_ready); end
        n_cmp++; if (rf_wbck_o_rdidx !== 5'd10 || rf_wbck_o_wdat !== 32'd100) begin n_err++; $display("FAIL full_head got=%0d/%h exp=10/64", rf_wbck_o_rdidx, rf_wbck_o_wdat); end
        tick();
        // cnt=3: ALU resumes, queue waits
        drive(1'b1, 5'd7, 32'hA0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd3) begin n_err++; $display("FAIL full_cnt3 got=%0d exp=3", longp_fifo_cnt); end
        n_cmp++; if (alu_wbck_i_ready !== 1'b1 || rf_wbck_o_rdidx !== 5'd7) begin n_err++; $display("FAIL full_alu_resume got=%b/%0d exp=1/7", alu_wbck_i_ready, rf_wbck_o_rdidx); end
        n_cmp++; if (longp_wbck_i_ready !== 1'b1) begin n_err++; $display("FAIL full_lp_ready3 got=%b exp=1", longp_wbck_i_ready); end
        tick();
        // ALU idle: drain in push order
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            n_cmp++; if (longp_fifo_cnt !== 3'(4 - i)) begin n_err++; $display("FAIL drain_cnt%0d got=%0d exp=%0d", i, longp_fifo_cnt, 4 - i); end
            n_cmp++; if (rf_wbck_o_ena !== 1'b1 || rf_wbck_o_rdidx !== 5'(10 + i) || rf_wbck_o_wdat !== 32'(100 + i)) begin n_err++; $display("FAIL drain_head%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, rf_wbck_o_ena, rf_wbck_o_rdidx, rf_wbck_o_wdat, 10 + i, 100 + i); end
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd0 || rf_wbck_o_ena !== 1'b0) begin n_err++; $display("FAIL drain_end got=%0d/%b exp=0/0", longp_fifo_cnt, rf_wbck_o_ena); end
        tick();
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (alu_wbck_i_ready !== 1'b1) begin n_err++; $display("FAIL x0_alu_ready got=%b exp=1", alu_wbck_i_ready); end
        n_cmp++; if (rf_wbck_o_ena !== 1'b0) begin n_err++; $display("FAIL x0_alu_ena got=%b exp=0", rf_wbck_o_ena); end
        tick();
        // ALU busy so the x0 long-pipe result is queued in both builds
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'h55);
        n_cmp++; if (rf_wbck_o_ena !== 1'b1 || rf_wbck_o_rdidx !== 5'd4) begin n_err++; $display("FAIL x0_alu4 got=%b/%0d exp=1/4", rf_wbck_o_ena, rf_wbck_o_rdidx); end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd1) begin n_err++; $display("FAIL x0_cnt1 got=%0d exp=1", longp_fifo_cnt); end
        n_cmp++; if (rf_wbck_o_ena !== 1'b0) begin n_err++; $display("FAIL x0_pop_ena got=%b exp=0", rf_wbck_o_ena); end
        n_cmp++; if (alu_wbck_i_ready !== 1'b0) begin n_err++; $display("FAIL x0_pop_alu_ready got=%b exp=0", alu_wbck_i_ready); end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL x0_cnt0 got=%0d exp=0", longp_fifo_cnt); end
        tick();
    endtask

    task automatic test_push_pop();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd6, 32'h66, 1'b1, 5'(20 + i), 32'(32'h200 + i));
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'h222);
        n_cmp++; if (longp_fifo_cnt !== 3'd2) begin n_err++; $display("FAIL pp_cnt_pre got=%0d exp=2", longp_fifo_cnt); end
        n_cmp++; if (longp_wbck_i_ready !== 1'b1) begin n_err++; $display("FAIL pp_lp_ready got=%b exp=1", longp_wbck_i_ready); end
        n_cmp++; if (rf_wbck_o_ena !== 1'b1 || rf_wbck_o_rdidx !== 5'd20 || rf_wbck_o_wdat !== 32'h200) begin n_err++; $display("FAIL pp_head got=%b/%0d/%h exp=1/20/200", rf_wbck_o_ena, rf_wbck_o_rdidx, rf_wbck_o_wdat); end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd2) begin n_err++; $display("FAIL pp_cnt_post got=%0d exp=2", longp_fifo_cnt); end
        n_cmp++; if (rf_wbck_o_rdidx !== 5'd21 || rf_wbck_o_wdat !== 32'h201) begin n_err++; $display("FAIL pp_next got=%0d/%h exp=21/201", rf_wbck_o_rdidx, rf_wbck_o_wdat); end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd1 || rf_wbck_o_rdidx !== 5'd22 || rf_wbck_o_wdat !== 32'h222) begin n_err++; $display("FAIL pp_last got=%0d/%0d/%h exp=1/22/222", longp_fifo_cnt, rf_wbck_o_rdidx, rf_wbck_o_wdat); end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL pp_empty got=%0d exp=0", longp_fifo_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd9, 32'h99, 1'b1, 5'(1 + i), 32'(32'h300 + i));
            tick();
        end
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd15, 32'h315);
        n_cmp++; if (longp_fifo_cnt !== 3'd3) begin n_err++; $display("FAIL rm_cnt3 got=%0d exp=3", longp_fifo_cnt); end
        rst = 1'b1;
        #1;
        n_cmp++; if (alu_wbck_i_ready !== 1'b0 || longp_wbck_i_ready !== 1'b0) begin n_err++; $display("FAIL rm_readies got=%b/%b exp=0/0", alu_wbck_i_ready, longp_wbck_i_ready); end
        n_cmp++; if (rf_wbck_o_ena !== 1'b0) begin n_err++; $display("FAIL rm_ena got=%b exp=0", rf_wbck_o_ena); end
        tick();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (longp_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL rm_cnt0 got=%0d exp=0", longp_fifo_cnt); end
        n_cmp++; if (rf_wbck_o_ena !== 1'b0) begin n_err++; $display("FAIL rm_no_stale got=%b exp=0", rf_wbck_o_ena); end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (rf_wbck_o_ena !== 1'b0 || longp_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL rm_after got=%b/%0d exp=0/0", rf_wbck_o_ena, longp_fifo_cnt); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        alu_wbck_i_valid = 1'b0; alu_wbck_i_wdat = '0; alu_wbck_i_rdidx = '0;
        longp_wbck_i_valid = 1'b0; longp_wbck_i_wdat = '0; longp_wbck_i_rdidx = '0;
        test_reset();
        test_alu_only();
        test_longp_idle();
        test_full();
        test_x0();
        test_push_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
